// File: rtl/ifc_buffer_reader_pkg.sv
// ifc_defs: shared FSM encodings and default geometry for the IFC buffer and its reader.
package ifc_defs;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_t;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_BUFFER_SIZE = 10;
    localparam int DEF_CLK_DIV     = 4;
endpackage

// File: rtl/ifc_buffer_reader_bit_timer.sv
// ifc_bit_timer: phase counter 0..CLK_DIV-1, restarted by start; flags the ser_clk rise point and bit end.
module ifc_bit_timer
    import ifc_defs::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic half_tick,
    output logic bit_tick
);
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] phase_q, phase_d;

    assign half_tick = phase_q == PW'(CLK_DIV / 2 - 1);
    assign bit_tick  = phase_q == PW'(CLK_DIV - 1);

    always_comb phase_d = (start || bit_tick) ? '0 : phase_q + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= '0;
        else        phase_q <= phase_d;
    end
endmodule

// File: rtl/ifc_buffer_reader.sv
// ifc_buffer_reader: tracks IFC buffer occupancy, fetches words and shifts them out MSB-first on a framed serial link.
// Define IFC_TX_PARITY_EN to append an even-parity bit after the LSB of every word.
module ifc_buffer_reader
    import ifc_defs::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
    parameter int CLK_DIV     = DEF_CLK_DIV
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_strobe,
    output logic                               rd_en,
    input  logic [DATA_WIDTH-1:0]              rd_data,
    input  logic                               tx_enable,
    input  logic                               ovf_clr,
    output logic                               ser_clk,
    output logic                               ser_data,
    output logic                               ser_frame,
    output logic [$clog2(BUFFER_SIZE+1)-1:0]   level,
    output logic                               overflow,
    output logic                               busy
);
    localparam int LW = $clog2(BUFFER_SIZE + 1);
`ifdef IFC_TX_PARITY_EN
    localparam int NB = DATA_WIDTH + 1;
`else
    localparam int NB = DATA_WIDTH;
`endif
    localparam int BW = $clog2(NB);

    state_t        state_q, state_d;
    logic [NB-1:0] sh_q, sh_d, load;
    logic [BW-1:0] bit_q, bit_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d, ser_clk_q, ser_clk_d, ser_frame_q, ser_frame_d;
    logic          half_tick, bit_tick, full;

`ifdef IFC_TX_PARITY_EN
    assign load = {rd_data, ^rd_data};
`else
    assign load = rd_data;
`endif

    assign rd_en     = state_q == FETCH;
    assign busy      = state_q != IDLE;
    assign full      = level_q == LW'(BUFFER_SIZE);
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign ser_clk   = ser_clk_q;
    assign ser_frame = ser_frame_q;
    // Bits shift out of the top and zeros fill in, so the line idles low once a word is done.
    assign ser_data  = sh_q[NB-1];

    ifc_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (state_q == LATCH),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE:  if (tx_enable && level_q != '0) state_d = FETCH;
            FETCH: state_d = LATCH;
            LATCH: begin
                state_d = SHIFT;
                sh_d    = load;
                bit_d   = '0;
            end
            SHIFT: if (bit_tick) begin
                sh_d    = {sh_q[NB-2:0], 1'b0};
                bit_d   = bit_q + BW'(1);
                state_d = (bit_q == BW'(NB - 1)) ? GAP : SHIFT;
            end
            GAP:     if (bit_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ser_frame_d = state_d == SHIFT;
        // Low for the first half of each bit period, high for the second half.
        ser_clk_d   = state_q == SHIFT && state_d == SHIFT && (half_tick || (ser_clk_q && !bit_tick));
        level_d     = level_q;
        if (wr_strobe && !rd_en && !full) level_d = level_q + LW'(1);
        else if (rd_en && !wr_strobe)     level_d = level_q - LW'(1);
        ovf_d       = (wr_strobe && !rd_en && full) || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            bit_q       <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            ser_clk_q   <= ser_clk_d;
            ser_frame_q <= ser_frame_d;
        end
    end
endmodule
